// File: rtl/sw_ctrl_if.sv
// Stopwatch control bundle: raw buttons in, control strobes and status out.
// The controller side takes the slave modport.
interface sw_ctrl_if #(
    parameter int LAP_W = 4
);
    logic             btn_start;
    logic             btn_split;
    logic             btn_clear;
    logic             cent_tick;
    logic             cnt_clr;
    logic             splitcheck;
    logic             running;
    logic             frozen;
    logic [LAP_W-1:0] lap_cnt;

    modport master (
        output btn_start,
        output btn_split,
        output btn_clear,
        input  cent_tick,
        input  cnt_clr,
        input  splitcheck,
        input  running,
        input  frozen,
        input  lap_cnt
    );

    modport slave (
        input  btn_start,
        input  btn_split,
        input  btn_clear,
        output cent_tick,
        output cnt_clr,
        output splitcheck,
        output running,
        output frozen,
        output lap_cnt
    );
endinterface

// File: rtl/sw_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/stop/idle FSM,
// centisecond divider, split/freeze mirror and saturating lap counter.
module sw_ctrl #(
    parameter int TICK_DIV = 1_000_000,
    parameter int LAP_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    sw_ctrl_if.slave    bus
);
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [LAP_W-1:0] LAP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Button vectors are ordered {clear, start, split}
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    logic [2:0] ev;
    logic       ev_clr;
    logic       ev_start;
    logic       ev_split;

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
    logic             tick_q;
    logic             tick_n;
    logic             clr_q;
    logic             clr_n;
    logic             split_q;
    logic             split_n;
    logic             run_q;
    logic             frozen_q;
    logic             frozen_n;
    logic [LAP_W-1:0] lap_q;
    logic [LAP_W-1:0] lap_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {bus.btn_clear, bus.btn_start, bus.btn_split};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ev = s2 & ~s3;

    // Only the highest-priority event of a cycle survives
    assign ev_clr   = ev[2];
    assign ev_start = ev[1] & ~ev[2];
    assign ev_split = ev[0] & ~ev[1] & ~ev[2];

    always_comb begin
        state_n  = state;
        div_n    = div;
        tick_n   = 1'b0;
        clr_n    = 1'b0;
        split_n  = 1'b0;
        frozen_n = frozen_q;
        lap_n    = lap_q;

        if (state == RUN) begin
            if (div == DIV_MAX) begin
                div_n  = '0;
                tick_n = 1'b1;
            end else begin
                div_n = div + DIV_W'(1);
            end
        end

        unique case (state)
            IDLE: begin
                if (ev_clr) begin
                    clr_n = 1'b1;
                    div_n = '0;
                end else if (ev_start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (ev_start) begin
                    state_n = STOP;
                end else if (ev_split) begin
                    split_n  = 1'b1;
                    frozen_n = ~frozen_q;
                    if (!frozen_q && lap_q != LAP_MAX)
                        lap_n = lap_q + LAP_W'(1);
                end
            end
            STOP: begin
                if (ev_clr) begin
                    clr_n   = 1'b1;
                    div_n   = '0;
                    lap_n   = '0;
                    state_n = IDLE;
                    // Release a frozen display together with the clear
                    if (frozen_q) begin
                        split_n  = 1'b1;
                        frozen_n = 1'b0;
                    end
                end else if (ev_start) begin
                    state_n = RUN;
                end else if (ev_split && frozen_q) begin
                    split_n  = 1'b1;
                    frozen_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            tick_q   <= 1'b0;
            clr_q    <= 1'b0;
            split_q  <= 1'b0;
            run_q    <= 1'b0;
            frozen_q <= 1'b0;
            lap_q    <= '0;
        end else begin
            state    <= state_n;
            div      <= div_n;
            tick_q   <= tick_n;
            clr_q    <= clr_n;
            split_q  <= split_n;
            run_q    <= (state_n == RUN);
            frozen_q <= frozen_n;
            lap_q    <= lap_n;
        end
    end

    assign bus.cent_tick  = tick_q;
    assign bus.cnt_clr    = clr_q;
    assign bus.splitcheck = split_q;
    assign bus.running    = run_q;
    assign bus.frozen     = frozen_q;
    assign bus.lap_cnt    = lap_q;
endmodule

// File: tb/tb_sw_ctrl.sv
// Self-checking bench for sw_ctrl: directed test-plan steps followed by
// random button traffic, compared every cycle with a reference model.
module tb_sw_ctrl;
    localparam int TD = 4;
    localparam int LW = 4;
    localparam int LAP_SAT = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sw_ctrl_if #(.LAP_W(LW)) bus();

    sw_ctrl #(
        .TICK_DIV(TD),
        .LAP_W   (LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0=idle 1=run 2=stop; run_cycles counts
    // clock cycles spent running since the last clear.
    int       mode;
    int       run_cycles;
    bit       m_frozen;
    int       m_lap;
    bit       m_tick;
    bit       m_clr;
    bit       m_split;
    bit [2:0] bprev;
    bit [2:0] d1;
    bit [2:0] d2;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cent_tick",  {31'd0, bus.cent_tick},  {31'd0, m_tick});
        chk("cnt_clr",    {31'd0, bus.cnt_clr},    {31'd0, m_clr});
        chk("splitcheck", {31'd0, bus.splitcheck}, {31'd0, m_split});
        chk("running",    {31'd0, bus.running},    (mode == 1) ? 32'd1 : 32'd0);
        chk("frozen",     {31'd0, bus.frozen},     {31'd0, m_frozen});
        chk("lap_cnt",    {28'd0, bus.lap_cnt},    32'(m_lap));
    endtask

    task automatic model_reset();
        mode       = 0;
        run_cycles = 0;
        m_frozen   = 0;
        m_lap      = 0;
        m_tick     = 0;
        m_clr      = 0;
        m_split    = 0;
        bprev      = '0;
        d1         = '0;
        d2         = '0;
    endtask

    // b = {clear, start, split} as sampled at this clock edge
    task automatic model_edge(bit [2:0] b);
        bit [2:0] act;
        act   = d2;
        d2    = d1;
        d1    = b & ~bprev;
        bprev = b;

        m_tick  = 0;
        m_clr   = 0;
        m_split = 0;
        if (mode == 1) begin
            run_cycles++;
            m_tick = (run_cycles % TD) == 0;
        end

        if (act[2]) begin
            if (mode == 0) begin
                m_clr = 1;
            end else if (mode == 2) begin
                m_clr      = 1;
                run_cycles = 0;
                m_lap      = 0;
                mode       = 0;
                if (m_frozen) begin
                    m_split  = 1;
                    m_frozen = 0;
                end
            end
        end else if (act[1]) begin
            if (mode == 1) mode = 2;
            else           mode = 1;
        end else if (act[0]) begin
            if (mode == 1) begin
                m_split  = 1;
                m_frozen = !m_frozen;
                if (m_frozen && m_lap < LAP_SAT) m_lap++;
            end else if (mode == 2 && m_frozen) begin
                m_split  = 1;
                m_frozen = 0;
            end
        end
    endtask

    task automatic step(bit cl, bit st, bit sp);
        bus.btn_clear = cl;
        bus.btn_start = st;
        bus.btn_split = sp;
        @(posedge clk);
        model_edge({cl, st, sp});
        #1;
        check_all();
    endtask

    task automatic steps(int n, bit cl, bit st, bit sp);
        for (int i = 0; i < n; i++) step(cl, st, sp);
    endtask

    task automatic press(bit cl, bit st, bit sp);
        step(cl, st, sp);
        steps(3, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        bus.btn_clear = 1'b0;
        bus.btn_start = 1'b0;
        bus.btn_split = 1'b0;
        #2;
        do_reset();

        // Start held for many cycles: a single transition to running
        steps(8, 0, 0, 0);
        steps(20, 0, 1, 0);
        chk("run_after_hold", {31'd0, bus.running}, 32'd1);
        steps(5, 0, 0, 0);

        // Two splits 20 cycles apart: freeze then release, one lap
        press(0, 0, 1);
        chk("frozen_set", {31'd0, bus.frozen}, 32'd1);
        steps(16, 0, 0, 0);
        press(0, 0, 1);
        chk("frozen_clr", {31'd0, bus.frozen}, 32'd0);
        chk("lap_one", {28'd0, bus.lap_cnt}, 32'd1);

        // Stop, long pause, resume continues the partial period
        press(0, 1, 0);
        steps(50, 0, 0, 0);
        chk("stopped", {31'd0, bus.running}, 32'd0);
        press(0, 1, 0);
        steps(10, 0, 0, 0);

        // Split, stop, clear: clear and release in the same cycle
        press(0, 0, 1);
        press(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("clr_pulse", {31'd0, bus.cnt_clr}, 32'd1);
        chk("clr_split", {31'd0, bus.splitcheck}, 32'd1);
        steps(2, 0, 0, 0);
        chk("lap_cleared", {28'd0, bus.lap_cnt}, 32'd0);

        // Clear in RUN is ignored; clear beats start in STOP
        press(0, 1, 0);
        steps(6, 0, 0, 0);
        press(1, 0, 0);
        chk("run_after_clr", {31'd0, bus.running}, 32'd1);
        press(0, 1, 0);
        press(1, 1, 0);
        chk("idle_after_both", {31'd0, bus.running}, 32'd0);

        // 34 splits in RUN saturate the lap counter
        press(0, 1, 0);
        for (int i = 0; i < 34; i++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        steps(3, 0, 0, 0);
        chk("lap_sat", {28'd0, bus.lap_cnt}, 32'(LAP_SAT));

        // Reset mid-run while frozen, with a split event in flight
        press(0, 0, 1);
        chk("frozen_pre_rst", {31'd0, bus.frozen}, 32'd1);
        step(0, 0, 1);
        do_reset();
        steps(4, 0, 0, 0);

        // Random button traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0);
        end
        steps(4, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
